// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM state
// encoding, digit-buffer entry layout and the inactive levels of the
// active-low display pins.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_t;

    // Digit buffer entry: {dp, blank, hex[3:0]}
    localparam int ENTRY_W   = 6;
    localparam int HEX_W     = 4;
    localparam int DP_BIT    = 5;
    localparam int BLANK_BIT = 4;
    localparam int HEX_LSB   = 0;

    // Everything on the display is active-low, so "off" is all ones.
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Entry value loaded into every buffer slot on reset: blank, no dp.
    localparam logic [ENTRY_W-1:0] ENTRY_BLANK = 6'b010000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex digit to seven-segment pattern decoder.
// Output order is {g,f,e,d,c,b,a}, active-low (0 = segment lit).
module seg_hex_decoder (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    // Standard 0-F glyphs, lower-case b and d so they differ from 8 and 0.
    always_comb begin
        o_seg = 7'h7F;
        case (i_hex)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode
// seven-segment display. Digits are lit one at a time, separated by an
// all-off blanking gap to avoid ghosting. The lit digit's buffer entry is
// copied into a shadow register when its window opens, so buffer writes
// never disturb a window already in progress.
// Optional build macro SEG_DIM_EN adds a 4-bit PWM brightness input.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int ON_CYCLES    = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                wr_en,
    input  logic [2:0]          wr_addr,
    input  logic [ENTRY_W-1:0]  wr_data,
    input  logic [N_DIGITS-1:0] digit_en,
`ifdef SEG_DIM_EN
    input  logic [3:0]          dim_level,
`endif
    output logic [N_DIGITS-1:0] AN,
    output logic [6:0]          seg,
    output logic                DP,
    output logic                frame_tick
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(max_int(ON_CYCLES, BLANK_CYCLES));

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t         r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_cur_digit;
    logic                r_first;
    logic [ENTRY_W-1:0]  r_shadow;
    logic [ENTRY_W-1:0]  r_buf [N_DIGITS];
`ifdef SEG_DIM_EN
    logic [3:0]          r_pwm;
    logic [3:0]          w_pwm_next;
`endif

    logic [IDX_W-1:0]    w_start;
    logic [N_DIGITS-1:0] w_rot;
    logic                w_found;
    logic [IDX_W-1:0]    w_offset;
    logic [IDX_W-1:0]    w_sel;
    logic                w_wrap;
    logic                w_load;
    logic [ENTRY_W-1:0]  w_entry;
    logic [IDX_W-1:0]    w_an_idx;
    logic [N_DIGITS-1:0] w_an_lit;
    logic [6:0]          w_dec;
    logic [6:0]          w_seg_lit;
    logic                w_dp_lit;

    // Digit buffer: one register per digit, written from upstream in any state.
    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_buf
            // Blank on reset, overwrite on a write strobe addressed here.
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    r_buf[gi] <= ENTRY_BLANK;
                end else if (wr_en && (wr_addr == IDX_W'(gi))) begin
                    r_buf[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // Next-digit search: rotate the enable mask so bit 0 is the first
    // candidate, then take the lowest set bit. The first selection after
    // reset or IDLE starts at digit 0 inclusive; otherwise just past the
    // current digit, wrapping naturally through the 3-bit index.
    assign w_start = r_first ? '0 : (r_cur_digit + IDX_W'(1));

    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_rot
            assign w_rot[gi] = digit_en[w_start + IDX_W'(gi)];
        end
    endgenerate

    // Lowest set bit of the rotated mask gives the distance to the next digit.
    always_comb begin
        w_found  = 1'b0;
        w_offset = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found  = 1'b1;
                w_offset = IDX_W'(i);
            end
        end
    end

    assign w_sel  = w_start + w_offset;
    // A selection at or below the previous digit means the scan wrapped.
    assign w_wrap = !r_first && (w_sel <= r_cur_digit);
    assign w_load = (r_state == BLANK) && (r_cnt == BLANK_LAST) && w_found;

    // Outputs are registered, so the lit pattern is decoded from the entry
    // that the shadow will hold in the next cycle. On the load edge that is
    // the buffer's current (pre-write) content, matching what gets latched.
    assign w_entry  = w_load ? r_buf[w_sel] : r_shadow;
    assign w_an_idx = w_load ? w_sel : r_cur_digit;
    assign w_an_lit = ~(N_DIGITS'(1) << w_an_idx);

    seg_hex_decoder u_dec (
        .i_hex (w_entry[HEX_LSB +: HEX_W]),
        .o_seg (w_dec)
    );

    assign w_seg_lit = w_entry[BLANK_BIT] ? SEG_OFF : w_dec;
    assign w_dp_lit  = w_entry[BLANK_BIT] ? 1'b1 : ~w_entry[DP_BIT];

`ifdef SEG_DIM_EN
    assign w_pwm_next = r_pwm + 4'd1;
`endif

    // Scan FSM with registered pin drivers: BLANK gap, ON window, IDLE when nothing is enabled.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= BLANK;
            r_cnt       <= '0;
            r_cur_digit <= '0;
            r_first     <= 1'b1;
            r_shadow    <= ENTRY_BLANK;
            AN          <= AN_OFF;
            seg         <= SEG_OFF;
            DP          <= 1'b1;
            frame_tick  <= 1'b0;
`ifdef SEG_DIM_EN
            r_pwm       <= '0;
`endif
        end else begin
            frame_tick <= 1'b0;
            case (r_state)
                IDLE: begin
                    AN  <= AN_OFF;
                    seg <= SEG_OFF;
                    DP  <= 1'b1;
                    if (|digit_en) begin
                        r_state <= BLANK;
                        r_cnt   <= '0;
                        r_first <= 1'b1;
                    end
                end

                BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        r_cnt <= '0;
                        if (w_found) begin
                            r_state     <= ON;
                            r_cur_digit <= w_sel;
                            r_shadow    <= r_buf[w_sel];
                            r_first     <= 1'b0;
                            frame_tick  <= w_wrap;
                            AN          <= w_an_lit;
                            seg         <= w_seg_lit;
                            DP          <= w_dp_lit;
`ifdef SEG_DIM_EN
                            r_pwm       <= '0;
`endif
                        end else begin
                            r_state <= IDLE;
                            AN      <= AN_OFF;
                            seg     <= SEG_OFF;
                            DP      <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        AN    <= AN_OFF;
                        seg   <= SEG_OFF;
                        DP    <= 1'b1;
                    end
                end

                ON: begin
                    if (r_cnt == ON_LAST) begin
                        r_state <= BLANK;
                        r_cnt   <= '0;
                        AN      <= AN_OFF;
                        seg     <= SEG_OFF;
                        DP      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
`ifdef SEG_DIM_EN
                        // Anode and segments only driven in the PWM on-phase.
                        r_pwm <= w_pwm_next;
                        if (w_pwm_next <= dim_level) begin
                            AN  <= w_an_lit;
                            seg <= w_seg_lit;
                            DP  <= w_dp_lit;
                        end else begin
                            AN  <= AN_OFF;
                            seg <= SEG_OFF;
                            DP  <= 1'b1;
                        end
`else
                        AN  <= w_an_lit;
                        seg <= w_seg_lit;
                        DP  <= w_dp_lit;
`endif
                    end
                end

                default: begin
                    r_state <= BLANK;
                    r_cnt   <= '0;
                    r_first <= 1'b1;
                    AN      <= AN_OFF;
                    seg     <= SEG_OFF;
                    DP      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with ON_CYCLES=4, BLANK_CYCLES=2.
// Stimulus pushes cycle-stamped expected pin values into a queue; a
// monitor on the falling edge pops every entry due in the current cycle
// and compares it with the DUT pins.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [5:0] wr_data;
    logic [7:0] digit_en;
    logic [7:0] AN;
    logic [6:0] seg;
    logic       DP;
    logic       frame_tick;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int scen   = 0;

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [6:0] sg;
        logic       dp;
        logic       ft;
        int         scen;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    seg_scan_ctrl #(
        .N_DIGITS     (8),
        .ON_CYCLES    (4),
        .BLANK_CYCLES (2)
    ) dut (
        .sys_clk    (clk),
        .sys_rst    (sys_rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .digit_en   (digit_en),
`ifdef SEG_DIM_EN
        .dim_level  (4'd15),
`endif
        .AN         (AN),
        .seg        (seg),
        .DP         (DP),
        .frame_tick (frame_tick)
    );

    // Monitor: compare every expectation that falls due in this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL missed_s%0d cyc %0d: expectation not checked in time (now %0d)",
                         e.scen, e.cyc, cyc);
            end else if ({AN, seg, DP, frame_tick} !== {e.an, e.sg, e.dp, e.ft}) begin
                errors++;
                $display("FAIL scan_s%0d cyc %0d: got AN=%h seg=%h DP=%b ft=%b, want AN=%h seg=%h DP=%b ft=%b",
                         e.scen, cyc, AN, seg, DP, frame_tick, e.an, e.sg, e.dp, e.ft);
            end
        end
    end

    task automatic exp1(input int c, input logic [7:0] an, input logic [6:0] sg,
                        input logic dp, input logic ft);
        exp_t e;
        e.cyc = c; e.an = an; e.sg = sg; e.dp = dp; e.ft = ft; e.scen = scen;
        q.push_back(e);
    endtask

    task automatic exp_win(input int c, input int n, input logic [7:0] an,
                           input logic [6:0] sg, input logic dp, input logic ft_first);
        for (int i = 0; i < n; i++)
            exp1(c + i, an, sg, dp, (i == 0) ? ft_first : 1'b0);
    endtask

    task automatic exp_off(input int c, input int n);
        exp_win(c, n, 8'hFF, 7'h7F, 1'b1, 1'b0);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Hold reset for a few cycles (checking the reset pin state), release on a falling edge.
    task automatic do_reset(input logic [7:0] en, output int r);
        @(negedge clk);
        sys_rst  = 1'b1;
        digit_en = en;
        wr_en    = 1'b0;
        exp_off(cyc + 1, 2);
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        r = cyc;
    endtask

    task automatic write_at(input int t, input logic [2:0] a, input logic [5:0] d);
        wait_cyc(t);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic set_en_at(input int t, input logic [7:0] en);
        wait_cyc(t);
        digit_en = en;
    endtask

    initial begin
        int r;
        logic [7:0] an_v;

        sys_rst  = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 6'd0;
        digit_en = 8'hFF;

        // 1: all digits enabled, blank buffer, full frame plus wrap tick.
        scen = 1;
        do_reset(8'hFF, r);
        exp_off(r + 1, 1);
        for (int d = 0; d < 8; d++) begin
            an_v = 8'hFF ^ (8'h01 << d);
            exp_win(r + 2 + 6 * d, 4, an_v, 7'h7F, 1'b1, 1'b0);
            exp_off(r + 6 + 6 * d, 2);
        end
        exp_win(r + 50, 1, 8'hFE, 7'h7F, 1'b1, 1'b1);
        wait_cyc(r + 52);

        // 3: digits 2 and 7 only, tick when 2 follows 7.
        scen = 3;
        do_reset(8'b1000_0100, r);
        exp_off(r + 1, 1);
        exp_win(r + 2, 4, 8'hFB, 7'h7F, 1'b1, 1'b0);
        exp_off(r + 6, 2);
        exp_win(r + 8, 4, 8'h7F, 7'h7F, 1'b1, 1'b0);
        exp_off(r + 12, 2);
        exp_win(r + 14, 4, 8'hFB, 7'h7F, 1'b1, 1'b1);
        exp_off(r + 18, 2);
        exp_win(r + 20, 4, 8'h7F, 7'h7F, 1'b1, 1'b0);
        exp_off(r + 24, 2);
        exp_win(r + 26, 1, 8'hFB, 7'h7F, 1'b1, 1'b1);
        wait_cyc(r + 28);

        // 4: nothing enabled -> IDLE; enable digit 0; disable mid-ON; re-enable.
        scen = 4;
        do_reset(8'h00, r);
        exp_off(r + 1, 7);
        exp_win(r + 8, 4, 8'hFE, 7'h7F, 1'b1, 1'b0);
        exp_off(r + 12, 2);
        exp_win(r + 14, 4, 8'hFE, 7'h7F, 1'b1, 1'b1);
        exp_off(r + 18, 7);
        exp_win(r + 25, 4, 8'hFE, 7'h7F, 1'b1, 1'b0);
        exp_off(r + 29, 2);
        exp_win(r + 31, 1, 8'hFE, 7'h7F, 1'b1, 1'b1);
        set_en_at(r + 5, 8'h01);
        set_en_at(r + 15, 8'h00);
        set_en_at(r + 22, 8'h01);
        wait_cyc(r + 33);

        // 2: decoded digits, mid-ON write, write on the latch edge, reset mid-ON.
        scen = 2;
        do_reset(8'h03, r);
        exp_off(r + 1, 1);
        exp_win(r + 2, 4, 8'hFE, 7'h00, 1'b1, 1'b0);
        exp_off(r + 6, 2);
        exp_win(r + 8, 4, 8'hFD, 7'b1111001, 1'b0, 1'b0);
        exp_off(r + 12, 2);
        exp_win(r + 14, 4, 8'hFE, 7'h00, 1'b1, 1'b1);
        exp_off(r + 18, 2);
        exp_win(r + 20, 4, 8'hFD, 7'b1111001, 1'b0, 1'b0);
        exp_off(r + 24, 2);
        exp_win(r + 26, 4, 8'hFE, 7'b0001000, 1'b1, 1'b1);
        exp_off(r + 30, 2);
        exp_win(r + 32, 4, 8'hFD, 7'b0100100, 1'b1, 1'b0);
        exp_off(r + 36, 2);
        exp_win(r + 38, 1, 8'hFE, 7'b0001000, 1'b1, 1'b1);
        write_at(r, 3'd0, 6'h08);
        write_at(r + 1, 3'd1, 6'h21);
        write_at(r + 15, 3'd0, 6'h0A);
        write_at(r + 19, 3'd1, 6'h02);
        wait_cyc(r + 38);
        @(posedge clk);
        #2;
        scen = 6;
        sys_rst = 1'b1;
        exp_off(r + 39, 1);

        // 6: after release the buffer is blank and the scan restarts at digit 0.
        do_reset(8'h03, r);
        exp_off(r + 1, 1);
        exp_win(r + 2, 4, 8'hFE, 7'h7F, 1'b1, 1'b0);
        exp_off(r + 6, 2);
        exp_win(r + 8, 4, 8'hFD, 7'h7F, 1'b1, 1'b0);
        wait_cyc(r + 13);
        repeat (2) @(negedge clk);

        if (q.size() != 0) begin
            $display("FAIL leftover: %0d expectations unchecked, required 0", q.size());
            checks += q.size();
            errors += q.size();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
